// File: rtl/rotated_frame_scanout_pkg.sv
// Shared constants for the rotated frame scan-out block.
//   GRID_SIZE  : piece bounding-box edge length
//   BOARD_COLS : unrotated board width (becomes the rotated row count)
//   BOARD_ROWS : unrotated board height (becomes the rotated row width)
//   IDLE/SCAN/DONE : frame sequencer state encodings
package rotated_frame_scanout_pkg;

  localparam int unsigned GRID_SIZE  = 4;
  localparam int unsigned BOARD_COLS = 10;
  localparam int unsigned BOARD_ROWS = 20;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Index width that never collapses to zero bits for degenerate sizes.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rotated_frame_scanout_row_overlay.sv
// Combinational compositing of one rotated-board row.
//   row      : rotated row number r being built
//   px, py   : rotated piece column / row origin
//   piece_en : overlay the piece when 1
//   screen   : fixed board state, screen[x'][r]
//   piece    : piece grid, piece[x][y]
//   row_data : bit x' = fixed cell OR covered piece cell
module row_overlay
  import rotated_frame_scanout_pkg::*;
#(
  parameter int unsigned GRID       = GRID_SIZE,
  parameter int unsigned BOARD_W_IN = BOARD_COLS,
  parameter int unsigned BOARD_H_IN = BOARD_ROWS
) (
  input  logic [$clog2(BOARD_W_IN)-1:0] row,
  input  logic [$clog2(BOARD_H_IN)-1:0] px,
  input  logic [$clog2(BOARD_W_IN)-1:0] py,
  input  logic                          piece_en,
  input  logic [BOARD_W_IN-1:0]         screen [BOARD_H_IN],
  input  logic [GRID-1:0]               piece  [GRID],
  output logic [BOARD_H_IN-1:0]         row_data
);

  localparam int unsigned XW = $clog2(BOARD_H_IN);
  localparam int unsigned YW = $clog2(BOARD_W_IN);
  localparam int unsigned GW = idx_width(GRID);

  // One extra bit so a negative offset wraps to a large value and fails the < GRID test.
  logic [YW:0] dy;
  logic        dy_in;
  assign dy    = {1'b0, row} - {1'b0, py};
  assign dy_in = dy < (YW + 1)'(GRID);

  for (genvar x = 0; x < BOARD_H_IN; x++) begin : gen_col
    logic [XW:0] dx;
    logic        dx_in;
    assign dx    = (XW + 1)'(x) - {1'b0, px};
    assign dx_in = dx < (XW + 1)'(GRID);
    // Piece cells outside the board have no column here, so they drop out naturally.
    assign row_data[x] = screen[x][row]
                       | (piece_en & dx_in & dy_in & piece[dx[GW-1:0]][dy[GW-1:0]]);
  end

endmodule

// File: rtl/rotated_frame_scanout.sv
// Captures one rotated board frame and streams it out row by row.
//   clk, reset         : rising-edge clock, synchronous active-high reset
//   frame_start        : capture the selected inputs and scan one frame (IDLE only)
//   dir_ccw            : 1 = use *_ccw inputs, 0 = use *_cw inputs
//   piece_en           : overlay the active piece
//   screen_cw/_ccw     : rotated fixed state [x'][y']
//   piece_cw/_ccw      : rotated piece grid [x][y]
//   piece_x_*/piece_y_*: rotated piece origin
//   row_data, row_idx  : registered output row and its number
//   row_valid/row_ready: row handshake
//   busy, frame_done   : frame in progress / one-cycle end-of-frame pulse
module rotated_frame_scanout
  import rotated_frame_scanout_pkg::*;
#(
  parameter int unsigned GRID       = GRID_SIZE,
  parameter int unsigned BOARD_W_IN = BOARD_COLS,
  parameter int unsigned BOARD_H_IN = BOARD_ROWS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic                          dir_ccw,
  input  logic                          piece_en,
  input  logic [BOARD_W_IN-1:0]         screen_cw   [BOARD_H_IN],
  input  logic [BOARD_W_IN-1:0]         screen_ccw  [BOARD_H_IN],
  input  logic [GRID-1:0]               piece_cw    [GRID],
  input  logic [GRID-1:0]               piece_ccw   [GRID],
  input  logic [$clog2(BOARD_H_IN)-1:0] piece_x_cw,
  input  logic [$clog2(BOARD_H_IN)-1:0] piece_x_ccw,
  input  logic [$clog2(BOARD_W_IN)-1:0] piece_y_cw,
  input  logic [$clog2(BOARD_W_IN)-1:0] piece_y_ccw,
  output logic [BOARD_H_IN-1:0]         row_data,
  output logic [$clog2(BOARD_W_IN)-1:0] row_idx,
  output logic                          row_valid,
  input  logic                          row_ready,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int unsigned XW = $clog2(BOARD_H_IN);
  localparam int unsigned YW = $clog2(BOARD_W_IN);
  localparam logic [YW-1:0] LAST_ROW = YW'(BOARD_W_IN - 1);

  logic [1:0] state;

  // Frame snapshot
  logic [BOARD_W_IN-1:0] snap_screen [BOARD_H_IN];
  logic [GRID-1:0]       snap_piece  [GRID];
  logic [XW-1:0]         snap_px;
  logic [YW-1:0]         snap_py;
  logic                  snap_en;

  // Orientation-selected live inputs
  logic [BOARD_W_IN-1:0] sel_screen [BOARD_H_IN];
  logic [GRID-1:0]       sel_piece  [GRID];
  logic [XW-1:0]         sel_px;
  logic [YW-1:0]         sel_py;

  // Overlay operands
  logic [BOARD_W_IN-1:0] ov_screen [BOARD_H_IN];
  logic [GRID-1:0]       ov_piece  [GRID];
  logic [XW-1:0]         ov_px;
  logic [YW-1:0]         ov_py;
  logic [YW-1:0]         ov_row;
  logic                  ov_en;
  logic [BOARD_H_IN-1:0] ov_data;

  always_comb begin
    for (int i = 0; i < BOARD_H_IN; i++) begin
      sel_screen[i] = dir_ccw ? screen_ccw[i] : screen_cw[i];
    end
    for (int i = 0; i < GRID; i++) begin
      sel_piece[i] = dir_ccw ? piece_ccw[i] : piece_cw[i];
    end
    sel_px = dir_ccw ? piece_x_ccw : piece_x_cw;
    sel_py = dir_ccw ? piece_y_ccw : piece_y_cw;
  end

  // A single overlay serves both cases: in IDLE it builds row 0 straight from the live
  // inputs being captured, during SCAN it builds the following row from the snapshot.
  // That lets row_data be registered with only one cycle of start latency.
  always_comb begin
    if (state == IDLE) begin
      for (int i = 0; i < BOARD_H_IN; i++) ov_screen[i] = sel_screen[i];
      for (int i = 0; i < GRID; i++)       ov_piece[i]  = sel_piece[i];
      ov_px  = sel_px;
      ov_py  = sel_py;
      ov_en  = piece_en;
      ov_row = '0;
    end else begin
      for (int i = 0; i < BOARD_H_IN; i++) ov_screen[i] = snap_screen[i];
      for (int i = 0; i < GRID; i++)       ov_piece[i]  = snap_piece[i];
      ov_px  = snap_px;
      ov_py  = snap_py;
      ov_en  = snap_en;
      ov_row = row_idx + YW'(1);
    end
  end

  row_overlay #(
    .GRID       (GRID),
    .BOARD_W_IN (BOARD_W_IN),
    .BOARD_H_IN (BOARD_H_IN)
  ) u_row_overlay (
    .row      (ov_row),
    .px       (ov_px),
    .py       (ov_py),
    .piece_en (ov_en),
    .screen   (ov_screen),
    .piece    (ov_piece),
    .row_data (ov_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      row_idx    <= '0;
      row_data   <= '0;
      row_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      snap_px    <= '0;
      snap_py    <= '0;
      snap_en    <= 1'b0;
      for (int i = 0; i < BOARD_H_IN; i++) snap_screen[i] <= '0;
      for (int i = 0; i < GRID; i++)       snap_piece[i]  <= '0;
    end else begin
      case (state)
        IDLE: begin
          frame_done <= 1'b0;
          if (frame_start) begin
            for (int i = 0; i < BOARD_H_IN; i++) snap_screen[i] <= sel_screen[i];
            for (int i = 0; i < GRID; i++)       snap_piece[i]  <= sel_piece[i];
            snap_px   <= sel_px;
            snap_py   <= sel_py;
            snap_en   <= piece_en;
            row_idx   <= '0;
            row_data  <= ov_data;
            row_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (row_ready) begin
            if (row_idx == LAST_ROW) begin
              row_valid  <= 1'b0;
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              row_idx  <= row_idx + YW'(1);
              row_data <= ov_data;
            end
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          row_valid  <= 1'b0;
          busy       <= 1'b0;
          frame_done <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rotated_frame_scanout.sv
// Self-checking bench for rotated_frame_scanout: directed scenarios plus randomized frames,
// each row compared with a cell-by-cell reference model of the captured snapshot.
module tb_rotated_frame_scanout;

  localparam int G = 4;
  localparam int W = 10;
  localparam int H = 20;

  logic         clk = 1'b0;
  logic         reset, frame_start, dir_ccw, piece_en, row_ready;
  logic [W-1:0] screen_cw [H];
  logic [W-1:0] screen_ccw [H];
  logic [G-1:0] piece_cw [G];
  logic [G-1:0] piece_ccw [G];
  logic [4:0]   piece_x_cw, piece_x_ccw;
  logic [3:0]   piece_y_cw, piece_y_ccw;
  logic [H-1:0] row_data;
  logic [3:0]   row_idx;
  logic         row_valid, busy, frame_done;

  int vectors = 0;
  int miscompares = 0;

  // Reference snapshot
  logic [W-1:0] m_screen [H];
  logic [G-1:0] m_piece [G];
  int           m_px, m_py;
  bit           m_en;

  always #5 clk = ~clk;

  rotated_frame_scanout dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .dir_ccw     (dir_ccw),
    .piece_en    (piece_en),
    .screen_cw   (screen_cw),
    .screen_ccw  (screen_ccw),
    .piece_cw    (piece_cw),
    .piece_ccw   (piece_ccw),
    .piece_x_cw  (piece_x_cw),
    .piece_x_ccw (piece_x_ccw),
    .piece_y_cw  (piece_y_cw),
    .piece_y_ccw (piece_y_ccw),
    .row_data    (row_data),
    .row_idx     (row_idx),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Board cell is lit if fixed, or if inside the piece box (on-board part) with a piece cell.
  function automatic logic [H-1:0] expect_row(input int r);
    logic [H-1:0] v;
    v = '0;
    for (int x = 0; x < H; x++) begin
      int dx, dy;
      dx = x - m_px;
      dy = r - m_py;
      v[x] = m_screen[x][r];
      if (m_en && dx >= 0 && dx < G && dy >= 0 && dy < G && m_piece[dx][dy]) v[x] = 1'b1;
    end
    return v;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < H; i++) begin
      screen_cw[i] = '0;
      screen_ccw[i] = '0;
    end
    for (int i = 0; i < G; i++) begin
      piece_cw[i] = '0;
      piece_ccw[i] = '0;
    end
    piece_x_cw = '0; piece_x_ccw = '0; piece_y_cw = '0; piece_y_ccw = '0;
    piece_en = 1'b0; dir_ccw = 1'b0;
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < H; i++) begin
      screen_cw[i]  = W'($urandom & $urandom & $urandom);
      screen_ccw[i] = W'($urandom & $urandom & $urandom);
    end
    for (int i = 0; i < G; i++) begin
      piece_cw[i]  = G'($urandom);
      piece_ccw[i] = G'($urandom);
    end
    piece_x_cw  = 5'($urandom_range(0, 22));
    piece_x_ccw = 5'($urandom_range(0, 22));
    piece_y_cw  = 4'($urandom_range(0, 12));
    piece_y_ccw = 4'($urandom_range(0, 12));
    piece_en = 1'($urandom);
    dir_ccw  = 1'($urandom);
  endtask

  // Record what the DUT should snapshot, then apply the capturing edge.
  task automatic capture(input bit keep_start);
    for (int i = 0; i < H; i++) m_screen[i] = dir_ccw ? screen_ccw[i] : screen_cw[i];
    for (int i = 0; i < G; i++) m_piece[i] = dir_ccw ? piece_ccw[i] : piece_cw[i];
    m_px = dir_ccw ? int'(piece_x_ccw) : int'(piece_x_cw);
    m_py = dir_ccw ? int'(piece_y_ccw) : int'(piece_y_cw);
    m_en = piece_en;
    frame_start = 1'b1;
    step();
    frame_start = keep_start;
  endtask

  // mode 0: ready always, 1: ready one cycle in three, 2: random ready
  task automatic run_frame(input int mode);
    int got = 0;
    int cyc = 0;
    while (got < W && cyc < 200) begin
      case (mode)
        0:       row_ready = 1'b1;
        1:       row_ready = (cyc % 3 == 2);
        default: row_ready = 1'($urandom);
      endcase
      check("row_valid", 32'(row_valid), 32'd1);
      check("busy", 32'(busy), 32'd1);
      check("frame_done_early", 32'(frame_done), 32'd0);
      check("row_idx", 32'(row_idx), 32'(got));
      check("row_data", 32'(row_data), 32'(expect_row(got)));
      if (row_ready) got++;
      step();
      cyc++;
      randomize_inputs(); // live inputs must not leak into an active frame
    end
    check("frame_rows", 32'(got), 32'(W));
    if (mode == 0) check("back_to_back_cycles", 32'(cyc), 32'(W));
    row_ready = 1'b0;
    check("done_pulse", 32'(frame_done), 32'd1);
    check("done_valid", 32'(row_valid), 32'd0);
    check("done_busy", 32'(busy), 32'd1);
    step();
    check("idle_done", 32'(frame_done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(row_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; row_ready = 1'b0;
    clear_inputs();
    step();
    step();
    reset = 1'b0;
    check("rst_valid", 32'(row_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_idx", 32'(row_idx), 32'd0);
    check("rst_data", 32'(row_data), 32'd0);

    // Empty board, no piece
    capture(1'b0);
    run_frame(0);

    // Single fixed cell at rotated column 19, row 0, CW orientation
    clear_inputs();
    for (int i = 0; i < H; i++) screen_ccw[i] = W'($urandom);
    screen_cw[19] = 10'h001;
    capture(1'b0);
    check("single_cell_row0", 32'(row_data), 32'h80000);
    run_frame(0);

    // Full piece clipped at the right edge, CCW orientation
    clear_inputs();
    for (int i = 0; i < G; i++) piece_ccw[i] = '1;
    for (int i = 0; i < G; i++) piece_cw[i] = G'($urandom);
    for (int i = 0; i < H; i++) screen_cw[i] = W'($urandom);
    piece_x_ccw = 5'd18; piece_y_ccw = 4'd8; piece_en = 1'b1; dir_ccw = 1'b1;
    capture(1'b0);
    check("clip_model_row8", 32'(expect_row(8)), 32'hC0000);
    run_frame(0);

    // Throttled consumer
    randomize_inputs();
    capture(1'b0);
    run_frame(1);

    // Random frames with random backpressure
    for (int f = 0; f < 6; f++) begin
      randomize_inputs();
      capture(1'b0);
      run_frame(2);
    end

    // Reset while row 4 is presented; reset beats a simultaneous frame_start
    randomize_inputs();
    capture(1'b0);
    row_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    row_ready = 1'b0;
    check("pre_reset_idx", 32'(row_idx), 32'd4);
    reset = 1'b1; frame_start = 1'b1;
    step();
    reset = 1'b0; frame_start = 1'b0;
    check("abort_valid", 32'(row_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(frame_done), 32'd0);
    check("abort_idx", 32'(row_idx), 32'd0);
    check("abort_data", 32'(row_data), 32'd0);
    step();
    check("abort_no_done", 32'(frame_done), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);
    randomize_inputs();
    capture(1'b0);
    run_frame(2);

    // frame_start held: one IDLE cycle between DONE and the next capture
    randomize_inputs();
    capture(1'b1);
    run_frame(0);
    capture(1'b1);
    frame_start = 1'b0;
    check("restart_valid", 32'(row_valid), 32'd1);
    check("restart_idx", 32'(row_idx), 32'd0);
    run_frame(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
